// File: rtl/ft245sync_responder.sv
// FT245 synchronous FIFO device-side model: plays the FTDI chip opposite a SyncFIFO master,
// bridging the pin bus to a host-side byte stream through two small FIFOs.
module ft245sync_responder #(
    parameter int unsigned RX_AW = 4,
    parameter int unsigned TX_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_clkout,
    // Pin side
    input  logic             i_oe_n,
    input  logic             i_rd_n,
    input  logic             i_wr_n,
    input  logic             i_siwu_n,
    input  logic [7:0]       i_data,
    output logic [7:0]       o_data,
    output logic             o_data_oe,
    output logic             o_rxf_n,
    output logic             o_txe_n,
    input  logic             i_hold_rxf,
    input  logic             i_hold_txe,
    // Host -> pins stream
    input  logic [7:0]       i_host_data,
    input  logic             i_host_valid,
    output logic             o_host_ready,
    // Pins -> host stream
    output logic [7:0]       o_host_data,
    output logic             o_host_valid,
    input  logic             i_host_ready,
    // Status
    output logic [RX_AW:0]   o_rx_level,
    output logic [TX_AW:0]   o_tx_level,
    output logic [2:0]       o_err
);

    localparam int unsigned RxDepth = 1 << RX_AW;
    localparam int unsigned TxDepth = 1 << TX_AW;
    localparam logic [RX_AW:0] RxFull = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0] TxFull = {1'b1, {TX_AW{1'b0}}};

    // SIWU# has no effect on this model.
    logic unused_siwu;
    assign unused_siwu = i_siwu_n;

    assign o_clkout = clk;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       rx_mem_q [RxDepth];
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d;
    logic [RX_AW-1:0] rx_rptr_q, rx_rptr_d;
    logic [RX_AW:0]   rx_count_q, rx_count_d;

    logic [7:0]       tx_mem_q [TxDepth];
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d;
    logic [TX_AW-1:0] tx_rptr_q, tx_rptr_d;
    logic [TX_AW:0]   tx_count_q, tx_count_d;

    logic             rxf_n_q, rxf_n_d;
    logic             txe_n_q, txe_n_d;
    logic             data_oe_q, data_oe_d;
    logic [2:0]       err_q, err_d;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic rx_push, rx_pop;
    logic tx_push, tx_pop;

    always_comb begin
        o_host_ready = (rx_count_q != RxFull);
        o_host_valid = (tx_count_q != '0);
        rx_push      = i_host_valid && o_host_ready;
        // Accepts use the registered flags, so a hold raised this cycle cannot cancel them.
        rx_pop       = !i_rd_n && !rxf_n_q && data_oe_q;
        tx_push      = !i_wr_n && !txe_n_q;
        tx_pop       = o_host_valid && i_host_ready;
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        if (rx_push) begin
            rx_wptr_d = rx_wptr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + 1'b1;
        end
        unique case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + 1'b1;
            2'b01:   rx_count_d = rx_count_q - 1'b1;
            default: rx_count_d = rx_count_q;
        endcase
    end

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_push) begin
            tx_wptr_d = tx_wptr_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + 1'b1;
        end
        unique case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase
    end

    always_comb begin
        rxf_n_d   = (rx_count_d == '0) || i_hold_rxf;
        txe_n_d   = (tx_count_d == TxFull) || i_hold_txe;
        data_oe_d = !i_oe_n;
        err_d     = err_q;
        if (!i_rd_n && !rx_pop) begin
            err_d[0] = 1'b1;
        end
        if (!i_wr_n && !tx_push) begin
            err_d[1] = 1'b1;
        end
        // Master driving the bus while we are also driving it.
        if (!i_wr_n && data_oe_q) begin
            err_d[2] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            rxf_n_q    <= 1'b1;
            txe_n_q    <= 1'b1;
            data_oe_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            rxf_n_q    <= rxf_n_d;
            txe_n_q    <= txe_n_d;
            data_oe_q  <= data_oe_d;
            err_q      <= err_d;
        end
    end

    // Storage arrays carry no reset; emptiness is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= i_host_data;
        end
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_data      = (rx_count_q != '0) ? rx_mem_q[rx_rptr_q] : 8'h00;
        o_host_data = tx_mem_q[tx_rptr_q];
        o_data_oe   = data_oe_q;
        o_rxf_n     = rxf_n_q;
        o_txe_n     = txe_n_q;
        o_rx_level  = rx_count_q;
        o_tx_level  = tx_count_q;
        o_err       = err_q;
    end

endmodule
